// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings and constants for the cpu_run_ctrl run/debug controller.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CRST   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_USER    = 2'd1,
        CAUSE_BREAK   = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } halt_cause_t;

    localparam int TRACE_DEPTH = 8;
    localparam int TRACE_IDX_W = $clog2(TRACE_DEPTH);

    // Core-reset hold counter; wide enough for hold times up to 15 cycles.
    localparam int RST_CNT_W = 4;

endpackage

// File: rtl/pc_trace_buf.sv
// pc_trace_buf: circular history of executed PCs with synchronous clear and
// combinational read, indexed backwards from the most recent entry.
module pc_trace_buf
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   we,
    input  logic [PC_W-1:0]        wdata,
    input  logic [TRACE_IDX_W-1:0] rd_idx,
    output logic [PC_W-1:0]        rd_data
);

    logic [PC_W-1:0]        mem [TRACE_DEPTH];
    logic [TRACE_IDX_W-1:0] wptr;
    logic [TRACE_IDX_W-1:0] rptr;

    // NOTE: the buffer is small and must read back as zero after reset, so the
    // storage is reset like ordinary flops instead of being left to a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TRACE_DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
        end else if (clr) begin
            for (int i = 0; i < TRACE_DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
        end else if (we) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + TRACE_IDX_W'(1);
        end
    end

    // Pointer arithmetic wraps naturally at the power-of-two depth.
    assign rptr    = wptr - TRACE_IDX_W'(1) - rd_idx;
    assign rd_data = mem[rptr];

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/debug sequencer for the single-cycle 16-bit core.
// Define CPU_RUN_CTRL_TRACE_EN to build the 8-entry executed-PC trace buffer.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W       = 16,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 455
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   step,
    input  logic                   abort,
    input  logic                   bp_en,
    input  logic [PC_W-1:0]        bp_addr,
    input  logic [PC_W-1:0]        pc,
    output logic                   core_en,
    output logic                   core_rst,
    output logic [2:0]             state,
    output logic [1:0]             halt_cause,
    output logic [CNT_W-1:0]       instr_cnt,
    input  logic [TRACE_IDX_W-1:0] trace_idx,
    output logic [PC_W-1:0]        trace_pc
);

    run_state_t           state_q;
    halt_cause_t          cause_q;
    logic [RST_CNT_W-1:0] rst_cnt;
    logic                 skip_bp;
    logic                 bp_hit;
    logic                 timeout_hit;
    logic [CNT_W-1:0]     cnt_inc;

    // skip_bp lets a resumed core execute the instruction it is parked on.
    assign bp_hit = bp_en && (pc == bp_addr) && !skip_bp;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        core_en = 1'b0;
        case (state_q)
            ST_RUN:  core_en = !bp_hit;
            ST_STEP: core_en = 1'b1;
            default: core_en = 1'b0;
        endcase
    end

    assign cnt_inc     = (&instr_cnt) ? instr_cnt : instr_cnt + CNT_W'(1);
    assign timeout_hit = (MAX_CYCLES != 0) && (cnt_inc == CNT_W'(MAX_CYCLES));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            core_rst  <= 1'b1;
            instr_cnt <= '0;
            rst_cnt   <= '0;
            skip_bp   <= 1'b0;
        end else if (abort) begin
            state_q  <= ST_IDLE;
            core_rst <= 1'b1;
            skip_bp  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_CRST;
                        cause_q   <= CAUSE_NONE;
                        instr_cnt <= '0;
                        rst_cnt   <= RST_CNT_W'(RST_CYCLES);
                        skip_bp   <= 1'b0;
                    end
                end
                ST_CRST: begin
                    rst_cnt <= rst_cnt - RST_CNT_W'(1);
                    if (rst_cnt <= RST_CNT_W'(1)) begin
                        state_q  <= ST_RUN;
                        core_rst <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (core_en) begin
                        instr_cnt <= cnt_inc;
                        skip_bp   <= 1'b0;
                    end
                    // A user stop outranks a breakpoint seen in the same cycle.
                    if (stop) begin
                        state_q <= ST_HALTED;
                        cause_q <= CAUSE_USER;
                    end else if (!core_en) begin
                        state_q <= ST_HALTED;
                        cause_q <= CAUSE_BREAK;
                    end else if (timeout_hit) begin
                        state_q <= ST_HALTED;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                ST_STEP: begin
                    instr_cnt <= cnt_inc;
                    skip_bp   <= 1'b0;
                    state_q   <= ST_HALTED;
                end
                ST_HALTED: begin
                    if (step) begin
                        state_q <= ST_STEP;
                    end else if (start && (cause_q != CAUSE_TIMEOUT)) begin
                        state_q <= ST_RUN;
                        skip_bp <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign halt_cause = cause_q;

`ifdef CPU_RUN_CTRL_TRACE_EN
    logic trace_clr;

    // Only a start taken from IDLE begins a fresh trace; resumes keep history.
    assign trace_clr = (state_q == ST_IDLE) && start && !abort;

    pc_trace_buf #(
        .PC_W (PC_W)
    ) u_trace (
        .clk     (clk),
        .rst     (rst),
        .clr     (trace_clr),
        .we      (core_en),
        .wdata   (pc),
        .rd_idx  (trace_idx),
        .rd_data (trace_pc)
    );
`else
    logic unused_trace_idx;

    assign unused_trace_idx = ^trace_idx;
    assign trace_pc         = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed and randomized checks of cpu_run_ctrl against a
// cycle-level behavioural model of the run/debug rules, with a simple core model.
module tb_cpu_run_ctrl;

    localparam int PC_W       = 16;
    localparam int CNT_W      = 32;
    localparam int RST_CYCLES = 2;
    localparam int MAX_CYCLES = 455;

    localparam int S_IDLE = 0, S_CRST = 1, S_RUN = 2, S_STEP = 3, S_HALTED = 4;
    localparam int C_NONE = 0, C_USER = 1, C_BREAK = 2, C_TIMEOUT = 3;

    logic             clk = 1'b0;
    logic             rst, start, stop, step, abort, bp_en;
    logic [PC_W-1:0]  bp_addr, pc;
    logic [2:0]       trace_idx;
    logic             core_en, core_rst;
    logic [2:0]       state;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] instr_cnt;
    logic [PC_W-1:0]  trace_pc;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .PC_W       (PC_W),
        .CNT_W      (CNT_W),
        .RST_CYCLES (RST_CYCLES),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .abort      (abort),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .core_en    (core_en),
        .core_rst   (core_rst),
        .state      (state),
        .halt_cause (halt_cause),
        .instr_cnt  (instr_cnt),
        .trace_idx  (trace_idx),
        .trace_pc   (trace_pc)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: run phase, halt reason, executed count, resume flag,
    // remaining core-reset cycles, and recent PC history (front = newest).
    int      m_state, m_cause, m_rst_left;
    longint  m_cnt;
    bit      m_skip;
    int      m_trace[$];
    bit      branchy;

    function automatic bit exp_en();
        if (m_state == S_STEP) return 1'b1;
        if (m_state == S_RUN)  return !(bp_en && pc == bp_addr && !m_skip);
        return 1'b0;
    endfunction

    function automatic bit exp_rst();
        return (m_state == S_IDLE) || (m_state == S_CRST);
    endfunction

    function automatic logic [PC_W-1:0] exp_trace(input int idx);
`ifdef CPU_RUN_CTRL_TRACE_EN
        return PC_W'(m_trace[idx]);
`else
        return '0;
`endif
    endfunction

    task automatic model_init();
        m_state = S_IDLE; m_cause = C_NONE; m_rst_left = 0; m_cnt = 0; m_skip = 0;
        m_trace.delete();
        repeat (8) m_trace.push_back(0);
    endtask

    task automatic model_step(input bit en);
        if (en) begin
            m_trace.push_front(int'(pc));
            void'(m_trace.pop_back());
            m_skip = 0;
            if (!abort && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        if (abort) begin
            m_state = S_IDLE;
            m_skip  = 0;
            return;
        end
        case (m_state)
            S_IDLE: if (start) begin
                m_state = S_CRST; m_cnt = 0; m_cause = C_NONE; m_rst_left = RST_CYCLES;
                m_trace.delete();
                repeat (8) m_trace.push_back(0);
            end
            S_CRST: begin
                m_rst_left--;
                if (m_rst_left == 0) m_state = S_RUN;
            end
            S_RUN: begin
                if (stop)             begin m_state = S_HALTED; m_cause = C_USER;  end
                else if (!en)         begin m_state = S_HALTED; m_cause = C_BREAK; end
                else if (MAX_CYCLES != 0 && m_cnt == MAX_CYCLES)
                                      begin m_state = S_HALTED; m_cause = C_TIMEOUT; end
            end
            S_STEP: m_state = S_HALTED;
            S_HALTED: begin
                if (step) m_state = S_STEP;
                else if (start && m_cause != C_TIMEOUT) begin m_state = S_RUN; m_skip = 1; end
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    // One clock: model and core advance on the edge; pulses drop afterwards.
    task automatic tick();
        bit en, crst;
        en   = exp_en();
        crst = exp_rst();
        @(posedge clk);
        #1;
        model_step(en);
        if (crst)
            pc = '0;
        else if (en)
            pc = (branchy && $urandom_range(0, 9) == 0) ? PC_W'($urandom_range(0, 15) * 4)
                                                        : pc + PC_W'(4);
        start = 0; stop = 0; step = 0; abort = 0;
        #2;
    endtask

    task automatic run_until(input int st, input int max_cycles);
        for (int i = 0; i < max_cycles && m_state != st; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1; start = 0; stop = 0; step = 0; abort = 0;
        bp_en = 0; bp_addr = '0; trace_idx = '0; pc = '0; branchy = 0;
        model_init();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #2;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
        total++; if (core_en !== 1'b0) begin bad++; $display("FAIL reset_core_en: got %b want 0", core_en); end
        total++; if (halt_cause !== 2'd0) begin bad++; $display("FAIL reset_cause: got %0d want 0", halt_cause); end
        total++; if (instr_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", instr_cnt); end
        for (int i = 0; i < 8; i++) begin
            trace_idx = 3'(i);
            #1;
            total++; if (trace_pc !== '0) begin bad++; $display("FAIL reset_trace[%0d]: got %h want 0", i, trace_pc); end
        end
        trace_idx = '0;
    endtask

    task automatic test_start_sequence();
        int rst_hi = 0;
        do_reset();
        start = 1;
        tick();
        for (int i = 0; i < 10 && core_rst === 1'b1; i++) begin
            rst_hi++;
            total++; if (core_en !== 1'b0) begin bad++; $display("FAIL crst_en: got %b want 0", core_en); end
            tick();
        end
        total++; if (rst_hi != RST_CYCLES) begin bad++; $display("FAIL crst_len: got %0d want %0d", rst_hi, RST_CYCLES); end
        total++; if (core_en !== 1'b1) begin bad++; $display("FAIL run_en_rise: got %b want 1", core_en); end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL run_state: got %0d want 2", state); end
        tick();
        total++; if (instr_cnt !== 32'd1) begin bad++; $display("FAIL first_cnt: got %0d want 1", instr_cnt); end
        tick();
        total++; if (instr_cnt !== 32'd2) begin bad++; $display("FAIL second_cnt: got %0d want 2", instr_cnt); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        bp_en = 1; bp_addr = 16'h0010;
        start = 1;
        tick();
        run_until(S_HALTED, 40);
        total++; if (state !== 3'd4) begin bad++; $display("FAIL bp_state: got %0d want 4", state); end
        total++; if (halt_cause !== 2'd2) begin bad++; $display("FAIL bp_cause: got %0d want 2", halt_cause); end
        total++; if (instr_cnt !== 32'd4) begin bad++; $display("FAIL bp_cnt: got %0d want 4", instr_cnt); end
        total++; if (core_en !== 1'b0) begin bad++; $display("FAIL bp_en_low: got %b want 0", core_en); end
        start = 1;
        tick();
        total++; if (core_en !== 1'b1) begin bad++; $display("FAIL resume_en: got %b want 1", core_en); end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL resume_state: got %0d want 2", state); end
        tick();
        total++; if (instr_cnt !== 32'd5) begin bad++; $display("FAIL resume_cnt: got %0d want 5", instr_cnt); end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL resume_running: got %0d want 2", state); end
        stop = 1;
        tick();
        total++; if (halt_cause !== 2'd1) begin bad++; $display("FAIL stop_cause: got %0d want 1", halt_cause); end
        total++; if (instr_cnt !== 32'd6) begin bad++; $display("FAIL stop_cnt: got %0d want 6", instr_cnt); end
    endtask

    task automatic test_step();
        int pulses = 0;
        do_reset();
        bp_en = 1; bp_addr = 16'h0010;
        start = 1;
        tick();
        run_until(S_HALTED, 40);
        total++; if (instr_cnt !== 32'd4) begin bad++; $display("FAIL step_pre_cnt: got %0d want 4", instr_cnt); end
        for (int k = 0; k < 3; k++) begin
            step = 1;
            if (core_en) pulses++;
            tick();
            if (core_en) pulses++;
            total++; if (state !== 3'd3) begin bad++; $display("FAIL step_state[%0d]: got %0d want 3", k, state); end
            tick();
            total++; if (state !== 3'd4) begin bad++; $display("FAIL step_back[%0d]: got %0d want 4", k, state); end
            repeat ($urandom_range(1, 4)) begin
                if (core_en) pulses++;
                tick();
            end
        end
        total++; if (pulses != 3) begin bad++; $display("FAIL step_pulses: got %0d want 3", pulses); end
        total++; if (instr_cnt !== 32'd7) begin bad++; $display("FAIL step_cnt: got %0d want 7", instr_cnt); end
        total++; if (halt_cause !== 2'd2) begin bad++; $display("FAIL step_cause: got %0d want 2", halt_cause); end
    endtask

    task automatic test_timeout();
        do_reset();
        start = 1;
        tick();
        run_until(S_HALTED, 600);
        total++; if (state !== 3'd4) begin bad++; $display("FAIL to_state: got %0d want 4", state); end
        total++; if (halt_cause !== 2'd3) begin bad++; $display("FAIL to_cause: got %0d want 3", halt_cause); end
        total++; if (instr_cnt !== 32'(MAX_CYCLES)) begin bad++; $display("FAIL to_cnt: got %0d want %0d", instr_cnt, MAX_CYCLES); end
        start = 1;
        tick();
        tick();
        total++; if (state !== 3'd4) begin bad++; $display("FAIL to_start_ignored: got %0d want 4", state); end
        total++; if (core_en !== 1'b0) begin bad++; $display("FAIL to_en: got %b want 0", core_en); end
        abort = 1;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL to_abort_state: got %0d want 0", state); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL to_abort_rst: got %b want 1", core_rst); end
        total++; if (instr_cnt !== 32'(MAX_CYCLES)) begin bad++; $display("FAIL to_abort_cnt: got %0d want %0d", instr_cnt, MAX_CYCLES); end
    endtask

    task automatic test_priority();
        do_reset();
        start = 1;
        tick();
        run_until(S_RUN, 10);
        tick();
        tick();
        stop = 1; abort = 1;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL stop_abort_state: got %0d want 0", state); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL stop_abort_rst: got %b want 1", core_rst); end
        total++; if (core_en !== 1'b0) begin bad++; $display("FAIL stop_abort_en: got %b want 0", core_en); end
        do_reset();
        bp_en = 1; bp_addr = 16'h0010;
        start = 1;
        tick();
        for (int i = 0; i < 40 && !(m_state == S_RUN && pc == 16'h0010); i++) tick();
        stop = 1;
        tick();
        total++; if (halt_cause !== 2'd1) begin bad++; $display("FAIL stop_on_bp_cause: got %0d want 1", halt_cause); end
        total++; if (instr_cnt !== 32'd4) begin bad++; $display("FAIL stop_on_bp_cnt: got %0d want 4", instr_cnt); end
    endtask

    task automatic test_trace();
        do_reset();
        start = 1;
        tick();
        run_until(S_RUN, 10);
        for (int i = 0; i < 20 && m_cnt < 9; i++) tick();
        stop = 1;
        tick();
        total++; if (instr_cnt !== 32'd10) begin bad++; $display("FAIL trace_cnt: got %0d want 10", instr_cnt); end
        trace_idx = 3'd0;
        #1;
`ifdef CPU_RUN_CTRL_TRACE_EN
        total++; if (trace_pc !== 16'h0024) begin bad++; $display("FAIL trace_newest: got %h want 0024", trace_pc); end
`else
        total++; if (trace_pc !== 16'h0000) begin bad++; $display("FAIL trace_off0: got %h want 0000", trace_pc); end
`endif
        trace_idx = 3'd7;
        #1;
`ifdef CPU_RUN_CTRL_TRACE_EN
        total++; if (trace_pc !== 16'h0008) begin bad++; $display("FAIL trace_oldest: got %h want 0008", trace_pc); end
`else
        total++; if (trace_pc !== 16'h0000) begin bad++; $display("FAIL trace_off7: got %h want 0000", trace_pc); end
`endif
        for (int i = 0; i < 8; i++) begin
            trace_idx = 3'(i);
            #1;
            total++; if (trace_pc !== exp_trace(i)) begin bad++; $display("FAIL trace_model[%0d]: got %h want %h", i, trace_pc, exp_trace(i)); end
        end
        trace_idx = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1;
        tick();
        run_until(S_RUN, 10);
        tick();
        tick();
        rst = 1;
        #1;
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL async_core_rst: got %b want 1", core_rst); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL async_state: got %0d want 0", state); end
        total++; if (core_en !== 1'b0) begin bad++; $display("FAIL async_en: got %b want 0", core_en); end
        total++; if (instr_cnt !== '0) begin bad++; $display("FAIL async_cnt: got %0d want 0", instr_cnt); end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        branchy = 1;
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) begin
                bp_en   = ($urandom_range(0, 3) != 0);
                bp_addr = PC_W'($urandom_range(0, 15) * 4);
            end
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            step      = ($urandom_range(0, 5) == 0);
            abort     = !exp_en() && ($urandom_range(0, 39) == 0);
            trace_idx = 3'($urandom_range(0, 7));
            #1;
            total++; if (state !== 3'(m_state)) begin bad++; $display("FAIL rnd_state@%0d: got %0d want %0d", c, state, m_state); end
            total++; if (core_en !== exp_en()) begin bad++; $display("FAIL rnd_en@%0d: got %b want %b", c, core_en, exp_en()); end
            total++; if (core_rst !== exp_rst()) begin bad++; $display("FAIL rnd_rst@%0d: got %b want %b", c, core_rst, exp_rst()); end
            total++; if (halt_cause !== 2'(m_cause)) begin bad++; $display("FAIL rnd_cause@%0d: got %0d want %0d", c, halt_cause, m_cause); end
            total++; if (instr_cnt !== 32'(m_cnt)) begin bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, instr_cnt, m_cnt); end
            total++; if (trace_pc !== exp_trace(int'(trace_idx))) begin bad++; $display("FAIL rnd_trace@%0d: got %h want %h", c, trace_pc, exp_trace(int'(trace_idx))); end
            tick();
        end
        branchy = 0;
    endtask

    initial begin
        test_reset();
        test_start_sequence();
        test_breakpoint();
        test_step();
        test_timeout();
        test_priority();
        test_trace();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
